alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on request and response.
// Single-cycle ops (add/sub, logic, upper-immediate, compares, shifts) answer one
// edge after accept; unsigned multiply (af=8) and divide (af=9) iterate one bit
// per edge and answer WIDTH+1 edges after accept.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   srcA, srcB           operands (WIDTH bits), captured on accept
//   af, i                operation select; i picks NOR (1) or upper-immediate (0) for af=7
//   in_valid, in_ready   request handshake
//   out_valid, out_ready response handshake
//   Alures, hi           primary result, upper product / remainder
//   zero, neg, ovfalu, divz  result flags
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       af,
  input  logic             i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Alures,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             neg,
  output logic             ovfalu,
  output logic             divz
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic             rstDone_q;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             zero_q, neg_q, ovf_q, divz_q;
  logic [WIDTH-1:0] accHi_q, accLo_q, opB_q;
  logic             isDiv_q, divByZero_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic [WIDTH-1:0] sum, diff, res_d;
  logic             ovf_d;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi_d, mulLo_d;
  logic [WIDTH:0]   remSh;
  logic             remGeq;
  logic [WIDTH-1:0] divRem_d, divQ_d;
  logic [WIDTH-1:0] nextHi_d, nextLo_d;

  // in_ready stays low until the first edge after reset release
  assign in_ready  = rstDone_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign Alures    = res_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovfalu    = ovf_q;
  assign divz      = divz_q;

  // Single-cycle result straight from the live inputs, registered on accept
  always_comb begin
    sum   = srcA + srcB;
    diff  = srcA - srcB;
    shamt = srcB[SHW-1:0];
    res_d = '0;
    ovf_d = 1'b0;
    case (af)
      4'd0: begin
        res_d = sum;
        ovf_d = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      4'd1: res_d = sum;
      4'd2: begin
        res_d = diff;
        ovf_d = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);
      end
      4'd3:  res_d = diff;
      4'd4:  res_d = srcA & srcB;
      4'd5:  res_d = srcA | srcB;
      4'd6:  res_d = srcA ^ srcB;
      4'd7:  res_d = i ? ~(srcA | srcB) : {srcB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd10: res_d = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      4'd11: res_d = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'd12: res_d = srcA << shamt;
      4'd13: res_d = srcA >> shamt;
      4'd14: res_d = WIDTH'($signed(srcA) >>> shamt);
      default: res_d = '0;
    endcase
  end

  // One iteration step. Multiply: accHi/accLo form the product register, low
  // half initially holds the multiplier, opB holds the multiplicand. Divide:
  // accHi is the partial remainder, accLo shifts the dividend out and the
  // quotient in, opB holds the divisor. A zero divisor naturally yields an
  // all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : {(WIDTH+1){1'b0}});
    mulHi_d  = mulSum[WIDTH:1];
    mulLo_d  = {mulSum[0], accLo_q[WIDTH-1:1]};
    remSh    = {accHi_q, accLo_q[WIDTH-1]};
    remGeq   = (remSh >= {1'b0, opB_q});
    divRem_d = remGeq ? WIDTH'(remSh - {1'b0, opB_q}) : remSh[WIDTH-1:0];
    divQ_d   = {accLo_q[WIDTH-2:0], remGeq};
    nextHi_d = isDiv_q ? divRem_d : mulHi_d;
    nextLo_d = isDiv_q ? divQ_d   : mulLo_d;
  end

  // Control FSM with registered results and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rstDone_q   <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      divz_q      <= 1'b0;
      accHi_q     <= '0;
      accLo_q     <= '0;
      opB_q       <= '0;
      isDiv_q     <= 1'b0;
      divByZero_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rstDone_q <= 1'b1;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (af == 4'd8 || af == 4'd9) begin
              state_q     <= BUSY;
              cnt_q       <= '0;
              isDiv_q     <= af[0];
              accHi_q     <= '0;
              accLo_q     <= af[0] ? srcA : srcB;
              opB_q       <= af[0] ? srcB : srcA;
              divByZero_q <= af[0] && (srcB == '0);
            end else begin
              state_q <= DONE;
              res_q   <= res_d;
              hi_q    <= '0;
              zero_q  <= (af != 4'd15) && (res_d == '0);
              neg_q   <= (af != 4'd15) && res_d[WIDTH-1];
              ovf_q   <= ovf_d;
              divz_q  <= 1'b0;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          accHi_q <= nextHi_d;
          accLo_q <= nextLo_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            res_q   <= nextLo_d;
            hi_q    <= nextHi_d;
            zero_q  <= (nextLo_d == '0);
            neg_q   <= nextLo_d[WIDTH-1];
            ovf_q   <= !isDiv_q && (nextHi_d != '0);
            divz_q  <= divByZero_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32) with directed cases
// and randomized requests compared against a behavioural model.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] srcA, srcB;
  logic [3:0]  af;
  logic        i;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic [31:0] Alures, hi;
  logic        zero, neg, ovfalu, divz;

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .af(af), .i(i),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .Alures(Alures), .hi(hi), .zero(zero), .neg(neg),
    .ovfalu(ovfalu), .divz(divz)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Behavioural reference computed with wide integer arithmetic
  function automatic void model(input logic [3:0] f, input logic ii, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] h, output logic z, output logic n,
                                output logic o, output logic dz, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; o = 1'b0; dz = 1'b0; lat = 1;
    case (f)
      4'd0: begin s = sa + sb; r = 32'(s); o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: r = a + b;
      4'd2: begin s = sa - sb; r = 32'(s); o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: r = a - b;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ii ? ~(a | b) : (b << 16);
      4'd8: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; h = p[63:32]; o = (h != 0); lat = 33; end
      4'd9: begin
        lat = 33;
        if (b == 0) begin r = 32'hFFFFFFFF; h = a; dz = 1'b1; end
        else begin r = a / b; h = a % b; end
      end
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = a << b[4:0];
      4'd13: r = a >> b[4:0];
      4'd14: r = 32'(sa >>> b[4:0]);
      default: r = '0;
    endcase
    z = (f != 4'd15) && (r == 0);
    n = (f != 4'd15) && r[31];
  endfunction

  // Issue one request, wait for its response and compare against the model.
  // rdyAfter sets out_ready once the request has been accepted.
  task automatic applyStimulus(input logic [3:0] f, input logic ii, input logic [31:0] a, input logic [31:0] b,
                               input logic rdyAfter);
    logic [31:0] r, h;
    logic z, n, o, dz, busyRdy;
    int lat, waitCnt;
    model(f, ii, a, b, r, h, z, n, o, dz, lat);
    waitCnt = 0;
    while (!in_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!in_ready) checkOutput("readyTimeout", {63'd0, in_ready}, 64'd1);
    af = f; i = ii; srcA = a; srcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = rdyAfter;
    srcA = $urandom; srcB = $urandom; af = 4'($urandom); i = 1'($urandom);
    waitCnt = 1;
    busyRdy = 1'b0;
    while (!out_valid && waitCnt < 100) begin
      if (in_ready) busyRdy = 1'b1;
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput($sformatf("latency af%0d", f), 64'(waitCnt), 64'(lat));
    if (lat > 1) checkOutput("busyInReady", {63'd0, busyRdy}, 64'd0);
    checkOutput($sformatf("Alures af%0d", f), {32'd0, Alures}, {32'd0, r});
    checkOutput($sformatf("hi af%0d", f), {32'd0, hi}, {32'd0, h});
    checkOutput($sformatf("flags af%0d", f), {60'd0, zero, neg, ovfalu, divz}, {60'd0, z, n, o, dz});
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Main sequence: reset, directed cases, hold/back-to-back, reset abort, random
  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    srcA = '0; srcB = '0; af = '0; i = 1'b0;
    #12;
    checkOutput("resetOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("resetInReady", {63'd0, in_ready}, 64'd0);
    checkOutput("resetOutputs", {Alures, hi}, 64'd0);
    checkOutput("resetFlags", {60'd0, zero, neg, ovfalu, divz}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 checkOutput("readyBeforeEdge", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("readyAfterEdge", {63'd0, in_ready}, 64'd1);

    applyStimulus(4'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 1'b1);
    checkOutput("addOverflow", {Alures, 28'd0, zero, neg, ovfalu, divz}, {32'h80000000, 28'd0, 4'b0110});
    applyStimulus(4'd8, 1'b0, 32'hFFFFFFFF, 32'd2, 1'b1);
    checkOutput("mulWrap", {Alures, hi}, {32'hFFFFFFFE, 32'd1});
    applyStimulus(4'd9, 1'b0, 32'd100, 32'd7, 1'b1);
    checkOutput("div100by7", {Alures, hi}, {32'd14, 32'd2});
    applyStimulus(4'd9, 1'b0, 32'd5, 32'd0, 1'b1);
    checkOutput("divByZero", {Alures, hi, 31'd0, divz}, {32'hFFFFFFFF, 32'd5, 32'd1});
    applyStimulus(4'd7, 1'b0, 32'hDEADBEEF, 32'h00001234, 1'b1);
    checkOutput("upperImm", {32'd0, Alures}, {32'd0, 32'h12340000});
    applyStimulus(4'd15, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    checkOutput("undefinedOp", {Alures, 28'd0, zero, neg, ovfalu, divz}, 64'd0);

    // Response held while the consumer stalls, then back-to-back accept
    applyStimulus(4'd3, 1'b0, 32'd5, 32'd5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d", k), {out_valid, zero, 30'd0, Alures}, {1'b1, 1'b1, 62'd0});
    end
    out_ready = 1'b1;
    applyStimulus(4'd14, 1'b0, 32'h80000000, 32'd4, 1'b1);
    checkOutput("sraNoBubble", {Alures, 31'd0, neg}, {32'hF8000000, 32'd1});

    // Reset pulse in the middle of a multiply aborts it
    af = 4'd8; i = 1'b0; srcA = 32'h12345678; srcB = 32'h9ABCDEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abortOutputs", {Alures, hi}, 64'd0);
    checkOutput("abortFlags", {58'd0, out_valid, in_ready, zero, neg, ovfalu, divz}, 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("abortNoResponse", 64'(seen), 64'd0);
    applyStimulus(4'd8, 1'b0, 32'd1000, 32'd3000, 1'b1);

    // Randomized requests
    for (int k = 0; k < 60; k++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom), pickOperand(), pickOperand(), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
